// File: rtl/sdrd_deserializer_if.sv
// Purpose: bundles the SDRD serial input, the host pop/status controls and
//          the FIFO read-side outputs of sdrd_deserializer.
// Signals:
//   sd_active, sd_strobe, sd_data : decode window, bit strobe, serial bit
//   rd_en, clr_status             : host pop request, sticky status clear
//   rd_data, empty, full, count   : FIFO head word and occupancy
//   overflow, abort               : sticky status flags
// Modports: master = sequencer/host side, slave = deserializer.
interface sdrd_deserializer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             sd_active;
  logic             sd_strobe;
  logic             sd_data;
  logic             rd_en;
  logic             clr_status;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             abort;

  modport master (
    output sd_active, sd_strobe, sd_data, rd_en, clr_status,
    input  rd_data, empty, full, count, overflow, abort
  );

  modport slave (
    input  sd_active, sd_strobe, sd_data, rd_en, clr_status,
    output rd_data, empty, full, count, overflow, abort
  );
endinterface

// File: rtl/sdrd_deserializer.sv
// Purpose: samples SDRD one bit per qualified strobe rising edge inside the
//          decode window, assembles WIDTH-bit words and queues them in a
//          show-ahead FIFO with sticky overflow/abort status.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : sdrd_deserializer_if.slave (serial input, host pop, FIFO status)
module sdrd_deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  sdrd_deserializer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             strb_q;

  logic             bit_acc_c;
  logic             push_c;
  logic             abort_set_c;
  logic             pop_c;
  logic             ovf_set_c;
  logic             write_c;
  logic [WIDTH-1:0] base_c;
  logic [WIDTH-1:0] shifted_c;
  logic [BW-1:0]    total_c;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q, abort_q;

  // Rising edge of the strobe inside the decode window.
  assign bit_acc_c = bus.sd_active & bus.sd_strobe & ~strb_q;

  // A word starts from zero in IDLE, so the first bit is a plain shift-in.
  assign base_c    = (state_q == IDLE) ? '0 : sr_q;
  assign total_c   = (state_q == IDLE) ? BW'(1) : bitcnt_q + BW'(1);
  assign shifted_c = MSB_FIRST ? ((base_c << 1) | WIDTH'(bus.sd_data))
                               : ((base_c >> 1) | (WIDTH'(bus.sd_data) << (WIDTH - 1)));

  // Receive FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      sr_q     <= '0;
      strb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      strb_q   <= bus.sd_strobe;
    end
  end

  // Receive FSM next state: shift, complete a word, or abort a partial one.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    sr_d        = sr_q;
    push_c      = 1'b0;
    abort_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bit_acc_c) begin
          if (total_c == BW'(WIDTH)) begin
            push_c   = 1'b1;
            bitcnt_d = '0;
            sr_d     = '0;
          end else begin
            state_d  = SHIFT;
            bitcnt_d = total_c;
            sr_d     = shifted_c;
          end
        end
      end
      SHIFT: begin
        if (!bus.sd_active) begin
          // Window closed with 0 < bitcnt < WIDTH.
          abort_set_c = 1'b1;
          state_d     = IDLE;
          bitcnt_d    = '0;
          sr_d        = '0;
        end else if (bit_acc_c) begin
          if (total_c == BW'(WIDTH)) begin
            push_c   = 1'b1;
            state_d  = IDLE;
            bitcnt_d = '0;
            sr_d     = '0;
          end else begin
            bitcnt_d = total_c;
            sr_d     = shifted_c;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop frees the head slot first, so push+pop succeeds even when full.
  assign pop_c     = bus.rd_en & (count_q != '0);
  assign ovf_set_c = push_c & (count_q == CW'(DEPTH)) & ~pop_c;
  assign write_c   = push_c & ~ovf_set_c;

  // FIFO storage, pointers, occupancy and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      if (write_c) begin
        mem_q[wr_ptr_q] <= shifted_c;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({write_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // Set wins over a same-cycle clear.
      overflow_q <= ovf_set_c   | (overflow_q & ~bus.clr_status);
      abort_q    <= abort_set_c | (abort_q    & ~bus.clr_status);
    end
  end

  // Show-ahead head; while empty this is a stale but stable slot.
  assign bus.rd_data  = mem_q[rd_ptr_q];
  assign bus.empty    = (count_q == '0);
  assign bus.full     = (count_q == CW'(DEPTH));
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.abort    = abort_q;
endmodule
